// File: rtl/mem_writer_pkg.sv
// mem_writer_pkg: shared widths, depth and FSM state type for the buffered memory writer
package mem_writer_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mem_writer_fifo_if.sv
// mem_writer_fifo_if: control (run/abort/length/busy/done/written), address stream, data stream and memory write port
interface mem_writer_fifo_if;
  import mem_writer_pkg::*;
  logic run, abort, busy, done;
  logic [CNT_W-1:0] length, written;
  logic gen_valid, gen_ready;
  logic [ADDR_W-1:0] gen_addr;
  logic data_valid, data_ready;
  logic [DATA_W-1:0] data_in;
  logic [STRB_W-1:0] data_strb;
  logic mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [STRB_W-1:0] mem_strb;
  modport master (
    input run, abort, length, gen_valid, gen_addr, data_valid, data_in, data_strb, mem_ready,
    output busy, done, written, gen_ready, data_ready, mem_valid, mem_addr, mem_data, mem_strb
  );
  modport slave (
    output run, abort, length, gen_valid, gen_addr, data_valid, data_in, data_strb, mem_ready,
    input busy, done, written, gen_ready, data_ready, mem_valid, mem_addr, mem_data, mem_strb
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; ports clk, rst, flush, push/din, pop/dout, full, empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] wp, rp;
  logic do_push, do_pop;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign empty = wp == rp;
  assign dout = mem[rp[PW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (PW+1)'(do_push);
      rp <= rp + (PW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[PW-1:0]] <= din;
endmodule

// File: rtl/mem_writer_fifo.sv
// mem_writer_fifo: pairs buffered address and data streams into counted, strobed memory writes with done pulse
module mem_writer_fifo
  import mem_writer_pkg::*;
(
  input logic clk,
  input logic rst,
  mem_writer_fifo_if.master bus
);
  state_t state, state_n;
  logic [CNT_W-1:0] len, addr_acc, data_acc;
  logic a_full, a_empty, d_full, d_empty, push_a, push_d, load, acc, start;
  logic [ADDR_W-1:0] a_out;
  logic [DATA_W+STRB_W-1:0] d_out;
  assign bus.gen_ready = state == RUN && !a_full && addr_acc < len;
  assign bus.data_ready = state == RUN && !d_full && data_acc < len;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign push_a = bus.gen_valid && bus.gen_ready;
  assign push_d = bus.data_valid && bus.data_ready;
  assign acc = bus.mem_valid && bus.mem_ready;
  assign load = !a_empty && !d_empty && (!bus.mem_valid || bus.mem_ready);
  assign start = state == IDLE && bus.run && !bus.abort;
  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_addr_fifo (
    .clk(clk), .rst(rst), .flush(bus.abort), .push(push_a), .din(bus.gen_addr),
    .pop(load), .dout(a_out), .full(a_full), .empty(a_empty)
  );
  sync_fifo #(.WIDTH(DATA_W+STRB_W), .DEPTH(DEPTH)) u_data_fifo (
    .clk(clk), .rst(rst), .flush(bus.abort), .push(push_d), .din({bus.data_in, bus.data_strb}),
    .pop(load), .dout(d_out), .full(d_full), .empty(d_empty)
  );
  always_comb
    state_n = bus.abort ? IDLE :
              state == IDLE  ? (bus.run ? (bus.length == '0 ? DONE : RUN) : IDLE) :
              state == RUN   ? (addr_acc == len && data_acc == len ? DRAIN : RUN) :
              state == DRAIN ? (bus.written == len ? DONE : DRAIN) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      len <= '0;
      addr_acc <= '0;
      data_acc <= '0;
      bus.written <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      bus.mem_strb <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        len <= bus.length;
        addr_acc <= '0;
        data_acc <= '0;
        bus.written <= '0;
      end else if (!bus.abort) begin
        addr_acc <= addr_acc + CNT_W'(push_a);
        data_acc <= data_acc + CNT_W'(push_d);
        bus.written <= bus.written + CNT_W'(acc);
      end
      if (bus.abort) bus.mem_valid <= 1'b0;
      else if (load) begin
        bus.mem_valid <= 1'b1;
        {bus.mem_addr, bus.mem_data, bus.mem_strb} <= {a_out, d_out};
      end else if (bus.mem_ready) bus.mem_valid <= 1'b0;
    end
endmodule
